test_status_monitor: RTL and testbench
======================================

TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

Interface
REQ-001 SHALL provide parameter NUM_CH, default 1, number of independent tohost channels (harts), range 1..16.
REQ-002 SHALL provide parameter CYC_W, default 64, width of the cycle counter and of max_cycles.
REQ-003 SHALL provide parameter CNT_W, default 32, width of the memory transaction counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  leaves IDLE and begins a monitored run.
REQ-007 tohost  input  NUM_CH*32  per-channel exit word; channel i occupies bits [32*i+31:32*i].
REQ-008 max_cycles  input  CYC_W  timeout limit; 0 disables the timeout.
REQ-009 mem_req_valid / mem_req_ready / mem_req_rw  input  1 each  memory request handshake to observe; rw=1 means write.
REQ-010 done  output  1  run finished (PASS, FAIL or TIMEOUT).
REQ-011 passed / failed / timed_out  output  1 each  one-hot terminal outcome.
REQ-012 fail_ch  output  max(1,clog2(NUM_CH))  index of the channel that caused FAIL.
REQ-013 exit_code  output  32  tohost value of fail_ch on FAIL, otherwise 0.
REQ-014 cycle_count  output  CYC_W  number of RUN cycles elapsed.
REQ-015 rd_count / wr_count  output  CNT_W each  accepted memory reads / writes during RUN.

Function
REQ-016 FSM states SHALL be IDLE, RUN, PASS, FAIL and TIMEOUT; PASS, FAIL and TIMEOUT are terminal and sticky until reset.
REQ-017 IDLE->RUN SHALL occur on a rising edge with start=1, clearing cycle_count, rd_count and wr_count on that edge; start is ignored in every other state.
REQ-018 In RUN, at each rising edge: if any channel has tohost>1 -> FAIL, with fail_ch = lowest such index and exit_code = its value.
REQ-019 Else, if every channel has tohost==1 -> PASS; channels with tohost==0 keep the run in RUN.
REQ-020 Else, if max_cycles!=0 and cycle_count>=max_cycles -> TIMEOUT.
REQ-021 Priority on simultaneous conditions SHALL be FAIL > PASS > TIMEOUT.
REQ-022 cycle_count SHALL increment on every RUN edge that does not leave RUN, saturate at all-ones, and freeze in terminal states.
REQ-023 All outputs SHALL be registered; an outcome is visible the cycle after the deciding edge, and done = passed|failed|timed_out.
REQ-024 The edge that leaves RUN SHALL still count a handshake occurring on it.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE and zero every output, including in the middle of a run; the next start after reset begins a fresh run.

Configuration
REQ-026 Macro TEST_MON_MEMSTAT_EN defined: rd_count / wr_count increment by 1 on each RUN edge with mem_req_valid&&mem_req_ready (rw selects the counter), saturating at all-ones.
REQ-027 TEST_MON_MEMSTAT_EN undefined: rd_count and wr_count SHALL be constant 0 and no counter flops are synthesised.

Verification
REQ-028 NUM_CH=1, start, tohost=1 driven on RUN cycle 3 -> passed=1, done=1 and cycle_count=3 on the following cycle.
REQ-029 NUM_CH=4, tohost={ch3=7, ch1=5, ch0=1, ch2=0} on the same edge -> failed=1, fail_ch=1, exit_code=5.
REQ-030 max_cycles=5, tohost held 0 -> timed_out=1 with cycle_count=5; a later tohost=1 leaves the outcome unchanged.
REQ-031 max_cycles=5, tohost=1 on the edge where cycle_count=5 -> passed=1 (PASS wins over TIMEOUT).
REQ-032 With TEST_MON_MEMSTAT_EN: 3 read and 2 write handshakes plus 1 valid-without-ready -> rd_count=3, wr_count=2; without the macro both are 0.
REQ-033 Reset asserted mid-RUN at cycle 10 -> all outputs 0 asynchronously; start again -> cycle_count restarts from 0.

Source files
------------

// File: rtl/test_status_monitor.sv
// ---------------------------------------------------------------------------
// test_status_monitor
//
// Watches a running test program and decides its outcome. After start, the
// monitor sits in RUN and on every clock edge looks at the per-channel tohost
// words: any word above 1 is a failure exit, all words equal to 1 is a pass,
// and otherwise the run goes on until the optional cycle limit expires. The
// outcome is sticky until reset. The monitor also counts RUN cycles and,
// optionally, accepted memory reads and writes.
//
// Optional feature macro: TEST_MON_MEMSTAT_EN
//   defined   -> rd_count / wr_count count accepted memory handshakes in RUN
//   undefined -> rd_count / wr_count are tied to 0 and have no flops
//
// Parameters:
//   NUM_CH  number of tohost channels (1..16)
//   CYC_W   width of cycle_count and max_cycles
//   CNT_W   width of rd_count and wr_count
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   reset          asynchronous active-high reset
//   start          begins a monitored run (only honoured in IDLE)
//   tohost         NUM_CH packed 32-bit exit words, channel i at [32*i +: 32]
//   max_cycles     timeout limit in RUN cycles, 0 disables the timeout
//   mem_req_valid  memory request valid
//   mem_req_ready  memory request ready
//   mem_req_rw     memory request direction, 1 = write
//   done           run finished with any outcome
//   passed         run ended with every channel reporting 1
//   failed         run ended with a channel reporting a value above 1
//   timed_out      run ended because the cycle limit was reached
//   fail_ch        lowest channel index that reported failure
//   exit_code      tohost word of fail_ch on failure, else 0
//   cycle_count    RUN cycles elapsed (saturating)
//   rd_count       accepted reads during RUN (saturating)
//   wr_count       accepted writes during RUN (saturating)
// ---------------------------------------------------------------------------
module test_status_monitor #(
  parameter int NUM_CH = 1,
  parameter int CYC_W  = 64,
  parameter int CNT_W  = 32,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_CH*32-1:0]  tohost,
  input  logic [CYC_W-1:0]      max_cycles,
  input  logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  input  logic                  mem_req_rw,
  output logic                  done,
  output logic                  passed,
  output logic                  failed,
  output logic                  timed_out,
  output logic [CH_W-1:0]       fail_ch,
  output logic [31:0]           exit_code,
  output logic [CYC_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      wr_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  logic [2:0]      state;
  logic            any_bad;
  logic            all_one;
  logic [CH_W-1:0] bad_idx;
  logic [31:0]     bad_val;
  logic            timeout_hit;

  // Scan all channels. Walking from the highest index down lets the lowest
  // failing channel overwrite the others, so it wins.
  always_comb begin
    any_bad = 1'b0;
    all_one = 1'b1;
    bad_idx = '0;
    bad_val = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (tohost[32*i +: 32] > 32'd1) begin
        any_bad = 1'b1;
        bad_idx = CH_W'(i);
        bad_val = tohost[32*i +: 32];
      end
      if (tohost[32*i +: 32] != 32'd1) begin
        all_one = 1'b0;
      end
    end
  end

  assign timeout_hit = (max_cycles != '0) && (cycle_count >= max_cycles);

  // Run controller. Outcome flags are their own flops so every output comes
  // straight from a register. The deciding edge leaves cycle_count untouched,
  // so it reports the number of RUN edges that stayed in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      done        <= 1'b0;
      passed      <= 1'b0;
      failed      <= 1'b0;
      timed_out   <= 1'b0;
      fail_ch     <= '0;
      exit_code   <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_RUN;
            cycle_count <= '0;
          end
        end
        ST_RUN: begin
          if (any_bad) begin
            state     <= ST_FAIL;
            done      <= 1'b1;
            failed    <= 1'b1;
            fail_ch   <= bad_idx;
            exit_code <= bad_val;
          end else if (all_one) begin
            state  <= ST_PASS;
            done   <= 1'b1;
            passed <= 1'b1;
          end else if (timeout_hit) begin
            state     <= ST_TIMEOUT;
            done      <= 1'b1;
            timed_out <= 1'b1;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + CYC_W'(1);
          end
        end
        ST_PASS, ST_FAIL, ST_TIMEOUT: begin
          state <= state;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TEST_MON_MEMSTAT_EN
  logic mem_hs;

  assign mem_hs = (state == ST_RUN) && mem_req_valid && mem_req_ready;

  // Memory statistics. Counters clear on the start edge and count every
  // accepted handshake in RUN, including the one on the edge that ends the
  // run, then freeze once the run is over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if ((state == ST_IDLE) && start) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (mem_hs) begin
      if (mem_req_rw) begin
        if (wr_count != '1) begin
          wr_count <= wr_count + CNT_W'(1);
        end
      end else begin
        if (rd_count != '1) begin
          rd_count <= rd_count + CNT_W'(1);
        end
      end
    end
  end
`else
  logic unused_mem;

  // Statistics disabled: counters are constant zero and the handshake
  // inputs are intentionally left unobserved.
  assign unused_mem = ^{mem_req_valid, mem_req_ready, mem_req_rw};
  assign rd_count   = '0;
  assign wr_count   = '0;
`endif

endmodule

// File: tb/tb_test_status_monitor.sv
// ---------------------------------------------------------------------------
// tb_test_status_monitor
//
// Drives two monitors from shared stimulus: dutA with one channel and the
// default widths, dutB with four channels, an 8-bit cycle counter and 4-bit
// memory counters so saturation is reachable. A behavioural model of the run
// outcome is stepped on every clock and reset event and compared against
// both instances shortly after each rising edge. Directed scenarios with
// literal expectations pin the model, followed by randomized runs.
// ---------------------------------------------------------------------------
module tb_test_status_monitor;

  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PASS    = 2;
  localparam int M_FAIL    = 3;
  localparam int M_TIMEOUT = 4;

`ifdef TEST_MON_MEMSTAT_EN
  localparam int MEMSTAT = 1;
`else
  localparam int MEMSTAT = 0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] tohost4;
  logic [7:0]   maxCycles;
  logic [63:0]  maxA;
  logic         memValid;
  logic         memReady;
  logic         memRw;

  logic         doneA, passedA, failedA, timedOutA;
  logic [0:0]   failChA;
  logic [31:0]  exitCodeA;
  logic [63:0]  cycleCountA;
  logic [31:0]  rdCountA, wrCountA;

  logic         doneB, passedB, failedB, timedOutB;
  logic [1:0]   failChB;
  logic [31:0]  exitCodeB;
  logic [7:0]   cycleCountB;
  logic [3:0]   rdCountB, wrCountB;

  int checks;
  int errors;
  bit compareEn;

  int          mPhase[2];
  logic [63:0] mCyc[2];
  logic [63:0] mRd[2];
  logic [63:0] mWr[2];
  int          mFailCh[2];
  logic [31:0] mExit[2];
  int          numCh[2];
  logic [63:0] cycMax[2];
  logic [63:0] cntMax[2];

  assign maxA = {56'd0, maxCycles};

  test_status_monitor #(.NUM_CH(1), .CYC_W(64), .CNT_W(32)) dutA (
    .clk(clk), .reset(reset), .start(start), .tohost(tohost4[31:0]),
    .max_cycles(maxA), .mem_req_valid(memValid), .mem_req_ready(memReady),
    .mem_req_rw(memRw), .done(doneA), .passed(passedA), .failed(failedA),
    .timed_out(timedOutA), .fail_ch(failChA), .exit_code(exitCodeA),
    .cycle_count(cycleCountA), .rd_count(rdCountA), .wr_count(wrCountA)
  );

  test_status_monitor #(.NUM_CH(4), .CYC_W(8), .CNT_W(4)) dutB (
    .clk(clk), .reset(reset), .start(start), .tohost(tohost4),
    .max_cycles(maxCycles), .mem_req_valid(memValid), .mem_req_ready(memReady),
    .mem_req_rw(memRw), .done(doneB), .passed(passedB), .failed(failedB),
    .timed_out(timedOutB), .fail_ch(failChB), .exit_code(exitCodeB),
    .cycle_count(cycleCountB), .rd_count(rdCountB), .wr_count(wrCountB)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the main sequence.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One model step: outcome rules evaluated from the inputs seen at an edge.
  task automatic modelStep(input int m);
    logic [31:0] v;
    bit          anyBad;
    bit          allOne;
    if (reset) begin
      mPhase[m]  = M_IDLE;
      mCyc[m]    = '0;
      mRd[m]     = '0;
      mWr[m]     = '0;
      mFailCh[m] = 0;
      mExit[m]   = '0;
    end else if (mPhase[m] == M_IDLE) begin
      if (start) begin
        mPhase[m] = M_RUN;
        mCyc[m]   = '0;
        mRd[m]    = '0;
        mWr[m]    = '0;
      end
    end else if (mPhase[m] == M_RUN) begin
      if (MEMSTAT == 1 && memValid && memReady) begin
        if (memRw) begin
          if (mWr[m] != cntMax[m]) mWr[m] = mWr[m] + 1;
        end else begin
          if (mRd[m] != cntMax[m]) mRd[m] = mRd[m] + 1;
        end
      end
      anyBad = 1'b0;
      allOne = 1'b1;
      for (int c = 0; c < numCh[m]; c++) begin
        v = tohost4[32*c +: 32];
        if (v > 1 && !anyBad) begin
          anyBad     = 1'b1;
          mFailCh[m] = c;
          mExit[m]   = v;
        end
        if (v != 1) allOne = 1'b0;
      end
      if (anyBad) mPhase[m] = M_FAIL;
      else if (allOne) mPhase[m] = M_PASS;
      else if (maxCycles != 0 && mCyc[m] >= 64'(maxCycles)) mPhase[m] = M_TIMEOUT;
      else if (mCyc[m] != cycMax[m]) mCyc[m] = mCyc[m] + 1;
    end
  endtask

  // Model thread, advanced on the same events that move the DUT.
  initial begin
    numCh[0]  = 1;
    numCh[1]  = 4;
    cycMax[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    cycMax[1] = 64'd255;
    cntMax[0] = 64'hFFFF_FFFF;
    cntMax[1] = 64'd15;
    for (int m = 0; m < 2; m++) begin
      mPhase[m] = M_IDLE; mCyc[m] = '0; mRd[m] = '0; mWr[m] = '0;
      mFailCh[m] = 0; mExit[m] = '0;
    end
    forever begin
      @(posedge clk or posedge reset);
      for (int m = 0; m < 2; m++) modelStep(m);
    end
  end

  task automatic checkAll();
    checkOutput("A.done", 64'(doneA), 64'(mPhase[0] >= M_PASS));
    checkOutput("A.passed", 64'(passedA), 64'(mPhase[0] == M_PASS));
    checkOutput("A.failed", 64'(failedA), 64'(mPhase[0] == M_FAIL));
    checkOutput("A.timed_out", 64'(timedOutA), 64'(mPhase[0] == M_TIMEOUT));
    checkOutput("A.fail_ch", 64'(failChA), 64'(mFailCh[0]));
    checkOutput("A.exit_code", 64'(exitCodeA), 64'(mExit[0]));
    checkOutput("A.cycle_count", cycleCountA, mCyc[0]);
    checkOutput("A.rd_count", 64'(rdCountA), mRd[0]);
    checkOutput("A.wr_count", 64'(wrCountA), mWr[0]);
    checkOutput("B.done", 64'(doneB), 64'(mPhase[1] >= M_PASS));
    checkOutput("B.passed", 64'(passedB), 64'(mPhase[1] == M_PASS));
    checkOutput("B.failed", 64'(failedB), 64'(mPhase[1] == M_FAIL));
    checkOutput("B.timed_out", 64'(timedOutB), 64'(mPhase[1] == M_TIMEOUT));
    checkOutput("B.fail_ch", 64'(failChB), 64'(mFailCh[1]));
    checkOutput("B.exit_code", 64'(exitCodeB), 64'(mExit[1]));
    checkOutput("B.cycle_count", 64'(cycleCountB), mCyc[1]);
    checkOutput("B.rd_count", 64'(rdCountB), mRd[1]);
    checkOutput("B.wr_count", 64'(wrCountB), mWr[1]);
  endtask

  // Compare process: every cycle, 2 units after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (compareEn) checkAll();
    end
  end

  // Drives one cycle's inputs at the falling edge; the next rising edge uses them.
  task automatic applyStimulus(input logic s, input logic [127:0] th, input logic [7:0] mx,
                               input logic v, input logic r, input logic w);
    @(negedge clk);
    start     = s;
    tohost4   = th;
    maxCycles = mx;
    memValid  = v;
    memReady  = r;
    memRw     = w;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #3;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    start = 1'b0; tohost4 = '0; memValid = 1'b0; memReady = 1'b0; memRw = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] randWord();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return 32'd0;
    if (r < 18) return 32'd1;
    if (r == 18) return 32'($urandom_range(2, 9));
    return $urandom;
  endfunction

  localparam logic [127:0] ALL_ONE = {4{32'd1}};

  initial begin
    logic [127:0] th;
    checks = 0; errors = 0; compareEn = 1'b0;
    reset = 1'b0; start = 1'b0; tohost4 = '0; maxCycles = '0;
    memValid = 1'b0; memReady = 1'b0; memRw = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    compareEn = 1'b1;

    // Reset state.
    #1;
    checkOutput("reset.done", 64'(doneA | doneB), 64'd0);
    checkOutput("reset.cycle_count", cycleCountA, 64'd0);

    // Pass on RUN cycle 3.
    applyStimulus(1'b1, '0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 8'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, ALL_ONE, 8'd0, 1'b0, 1'b0, 1'b0);
    afterEdge();
    checkOutput("pass3.passed", 64'(passedA), 64'd1);
    checkOutput("pass3.done", 64'(doneA), 64'd1);
    checkOutput("pass3.cycle_count", cycleCountA, 64'd3);
    checkOutput("pass3.B.cycle_count", 64'(cycleCountB), 64'd3);

    // Lowest failing channel wins; channel 0 alone passes dutA.
    doReset();
    applyStimulus(1'b1, '0, 8'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, {32'd7, 32'd0, 32'd5, 32'd1}, 8'd0, 1'b0, 1'b0, 1'b0);
    afterEdge();
    checkOutput("fail.failed", 64'(failedB), 64'd1);
    checkOutput("fail.fail_ch", 64'(failChB), 64'd1);
    checkOutput("fail.exit_code", 64'(exitCodeB), 64'd5);
    checkOutput("fail.A.passed", 64'(passedA), 64'd1);

    // Timeout at 5, then sticky against a later pass value.
    doReset();
    applyStimulus(1'b1, '0, 8'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 8'd5, 1'b0, 1'b0, 1'b0);
    afterEdge();
    checkOutput("tmo.timed_out", 64'(timedOutA), 64'd1);
    checkOutput("tmo.cycle_count", cycleCountA, 64'd5);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, ALL_ONE, 8'd5, 1'b0, 1'b0, 1'b0);
    afterEdge();
    checkOutput("tmo.sticky_timed_out", 64'(timedOutB), 64'd1);
    checkOutput("tmo.sticky_passed", 64'(passedB), 64'd0);

    // Pass beats timeout on the same edge.
    doReset();
    applyStimulus(1'b1, '0, 8'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 8'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, ALL_ONE, 8'd5, 1'b0, 1'b0, 1'b0);
    afterEdge();
    checkOutput("prio.passed", 64'(passedA), 64'd1);
    checkOutput("prio.timed_out", 64'(timedOutA), 64'd0);
    checkOutput("prio.cycle_count", cycleCountA, 64'd5);

    // Memory statistics, including a write on the edge that ends the run.
    doReset();
    applyStimulus(1'b1, '0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 8'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 8'd0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 8'd0, 1'b1, 1'b0, 1'b0);
    afterEdge();
    checkOutput("mem.rd_count", 64'(rdCountA), 64'(3 * MEMSTAT));
    checkOutput("mem.wr_count", 64'(wrCountA), 64'(2 * MEMSTAT));
    applyStimulus(1'b0, ALL_ONE, 8'd0, 1'b1, 1'b1, 1'b1);
    afterEdge();
    checkOutput("mem.last_edge_wr", 64'(wrCountB), 64'(3 * MEMSTAT));

    // Saturation of dutB's narrow counters.
    doReset();
    applyStimulus(1'b1, '0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, '0, 8'd0, 1'b1, 1'b1, 1'b0);
    afterEdge();
    checkOutput("sat.A.cycle_count", cycleCountA, 64'd300);
    checkOutput("sat.B.cycle_count", 64'(cycleCountB), 64'd255);
    checkOutput("sat.A.rd_count", 64'(rdCountA), 64'(300 * MEMSTAT));
    checkOutput("sat.B.rd_count", 64'(rdCountB), 64'(15 * MEMSTAT));

    // Asynchronous reset in the middle of a run, then a fresh run.
    doReset();
    applyStimulus(1'b1, '0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 8'd0, 1'b0, 1'b0, 1'b0);
    afterEdge();
    checkOutput("mid.cycle_count", cycleCountA, 64'd10);
    #3 reset = 1'b1;
    #1;
    checkOutput("mid.reset_cycle_count", cycleCountA, 64'd0);
    checkOutput("mid.reset_B_cycle_count", 64'(cycleCountB), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, '0, 8'd0, 1'b0, 1'b0, 1'b0);
    afterEdge();
    checkOutput("restart.cycle_count", cycleCountA, 64'd0);
    applyStimulus(1'b1, '0, 8'd0, 1'b0, 1'b0, 1'b0);
    afterEdge();
    checkOutput("restart.cycle_count_1", cycleCountA, 64'd1);

    // Randomized runs checked by the compare process.
    for (int run = 0; run < 25; run++) begin
      logic [7:0] mx;
      doReset();
      mx = 8'($urandom_range(0, 20));
      applyStimulus(1'b1, '0, mx, 1'b0, 1'b0, 1'b0);
      for (int cyc = 0; cyc < 30; cyc++) begin
        for (int c = 0; c < 4; c++) th[32*c +: 32] = randWord();
        applyStimulus(1'($urandom_range(0, 1)), th, mx, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    afterEdge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
